mexor_pipe: RTL

Parametrised, pipelined successor to the combinational mexor reversible XOR network. It applies a reversible adjacent-XOR transform (forward) or its exact inverse (prefix-XOR) to a WIDTH-bit word. A per-transaction mode bit selects the direction. Words move through a STAGES-deep valid/ready pipeline with full backpressure. It sits between the register file and the ALU result bus of the reversible datapath and also serves as a standalone reversibility test vehicle.

---
 rtl/mexor_pkg.sv | 49 ++++
 rtl/mexor_xform.sv | 27 ++
 rtl/mexor_pipe.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mexor_pkg.sv
// mexor_pkg: shared mode encoding and the reversible adjacent-XOR transforms.
// Both transforms work on a MEXOR_MAX_W-bit container. Only the low 'width'
// bits carry the operand. Bits above 'width' are forced to zero.
package mexor_pkg;

  localparam int MEXOR_MAX_W = 64;

  typedef enum logic {
    MODE_FWD = 1'b0,
    MODE_INV = 1'b1
  } mexor_mode_e;

  // Mask that keeps the low 'width' bits of the container.
  function automatic logic [MEXOR_MAX_W-1:0] mexor_mask(input int width);
    return {MEXOR_MAX_W{1'b1}} >> (MEXOR_MAX_W - width);
  endfunction

  // Forward transform: every bit is XORed with its upper neighbour, and the
  // MSB passes through. The zero bit above the operand makes the MSB pass
  // through without any special case.
  function automatic logic [MEXOR_MAX_W-1:0] mexor_fwd(
    input logic [MEXOR_MAX_W-1:0] x,
    input int                     width
  );
    logic [MEXOR_MAX_W-1:0] xm;
    xm = x & mexor_mask(width);
    return xm ^ (xm >> 1);
  endfunction

  // Inverse transform: a running XOR from the MSB down. This undoes
  // mexor_fwd exactly.
  function automatic logic [MEXOR_MAX_W-1:0] mexor_inv(
    input logic [MEXOR_MAX_W-1:0] x,
    input int                     width
  );
    logic [MEXOR_MAX_W-1:0] xm;
    logic [MEXOR_MAX_W-1:0] r;
    logic                   acc;
    xm  = x & mexor_mask(width);
    r   = '0;
    acc = 1'b0;
    for (int i = MEXOR_MAX_W - 1; i >= 0; i--) begin
      acc  = acc ^ xm[i];
      r[i] = acc;
    end
    return r;
  endfunction

endpackage

// File: rtl/mexor_xform.sv
// mexor_xform: a purely combinational forward or inverse mexor transform on a
// WIDTH-bit word. The mode input selects the direction.
module mexor_xform
  import mexor_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] data_o
);

  mexor_mode_e modeSel;

  assign modeSel = mexor_mode_e'(mode_i);

  // Pick the direction. The operand is widened into the package container
  // and then narrowed back.
  always_comb begin
    if (modeSel == MODE_INV) begin
      data_o = WIDTH'(mexor_inv(MEXOR_MAX_W'(data_i), WIDTH));
    end else begin
      data_o = WIDTH'(mexor_fwd(MEXOR_MAX_W'(data_i), WIDTH));
    end
  end

endmodule

// File: rtl/mexor_pipe.sv
// mexor_pipe: STAGES-deep valid/ready pipeline around the mexor transform.
// The transform feeds stage 0. Later stages only move words forward, and
// empty stages collapse so that bubbles disappear.
// Optional feature: define MEXOR_CHECK_EN to carry the original operand down
// the pipe. The last stage then applies the opposite transform and compares it
// with that operand, which flags round-trip errors on check_err.
module mexor_pipe
  import mexor_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic             check_err
);

  localparam int LAST = STAGES - 1;

  logic             stageValid_q [STAGES];
  logic [WIDTH-1:0] stageData_q  [STAGES];
  logic             stageMode_q  [STAGES];
  logic             stageLoad    [STAGES];
  logic [WIDTH-1:0] stageDataIn  [STAGES];
  logic             stageModeIn  [STAGES];
  logic [STAGES-1:0] advance;
  logic [WIDTH-1:0] xformData;
  logic             inFire;
  logic             outFire;
  logic [CNT_W-1:0] xferCnt_q;
  logic [CNT_W-1:0] xferCnt_d;

  mexor_xform #(
    .WIDTH (WIDTH)
  ) uXform (
    .data_i (in_data),
    .mode_i (in_mode),
    .data_o (xformData)
  );

  // A stage moves its word on when the stage after it is empty or is moving
  // on too. This chain runs from the output back to the input.
  always_comb begin
    advance       = '0;
    advance[LAST] = stageValid_q[LAST] && out_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      advance[k] = stageValid_q[k] && (!stageValid_q[k+1] || advance[k+1]);
    end
  end

  assign in_ready  = !stageValid_q[0] || advance[0];
  assign inFire    = in_valid && in_ready;
  assign outFire   = stageValid_q[LAST] && out_ready;

  assign out_valid = stageValid_q[LAST];
  assign out_data  = stageData_q[LAST];
  assign out_mode  = stageMode_q[LAST];

  for (genvar k = 0; k < STAGES; k++) begin : gStage
    if (k == 0) begin : gHead
      assign stageLoad[k]   = inFire;
      assign stageDataIn[k] = xformData;
      assign stageModeIn[k] = in_mode;
    end else begin : gBody
      assign stageLoad[k]   = advance[k-1];
      assign stageDataIn[k] = stageData_q[k-1];
      assign stageModeIn[k] = stageMode_q[k-1];
    end

    // Pipeline stage: take in a new word, empty out after handing the word on, or hold.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stageValid_q[k] <= 1'b0;
        stageData_q[k]  <= '0;
        stageMode_q[k]  <= 1'b0;
      end else if (stageLoad[k]) begin
        stageValid_q[k] <= 1'b1;
        stageData_q[k]  <= stageDataIn[k];
        stageMode_q[k]  <= stageModeIn[k];
      end else if (advance[k]) begin
        stageValid_q[k] <= 1'b0;
      end
    end
  end

  assign xferCnt_d = inFire ? xferCnt_q + CNT_W'(1) : xferCnt_q;

  // Count accepted input words. The count wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xferCnt_q <= '0;
    end else begin
      xferCnt_q <= xferCnt_d;
    end
  end

  assign xfer_cnt = xferCnt_q;

`ifdef MEXOR_CHECK_EN

  logic [WIDTH-1:0] stageOrig_q  [STAGES];
  logic [WIDTH-1:0] stageOrigIn  [STAGES];
  logic [WIDTH-1:0] recoveredData;
  logic             checkErr_q;
  logic             checkErr_d;

  for (genvar k = 0; k < STAGES; k++) begin : gShadow
    if (k == 0) begin : gHead
      assign stageOrigIn[k] = in_data;
    end else begin : gBody
      assign stageOrigIn[k] = stageOrig_q[k-1];
    end

    // Shadow copy of the original operand. It moves in step with the data stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stageOrig_q[k] <= '0;
      end else if (stageLoad[k]) begin
        stageOrig_q[k] <= stageOrigIn[k];
      end
    end
  end

  mexor_xform #(
    .WIDTH (WIDTH)
  ) uCheckXform (
    .data_i (stageData_q[LAST]),
    .mode_i (!stageMode_q[LAST]),
    .data_o (recoveredData)
  );

  assign checkErr_d = checkErr_q ||
                      (outFire && (recoveredData != stageOrig_q[LAST]));

  // Sticky round-trip error. It is judged only when a word actually leaves the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checkErr_q <= 1'b0;
    end else begin
      checkErr_q <= checkErr_d;
    end
  end

  assign check_err = checkErr_q;

`else

  assign check_err = 1'b0;

`endif

endmodule
